svm_sample_sequencer: RTL and testbench

SVM_SAMPLE_SEQUENCER -- requirements
Module: svm_sample_sequencer

---
 rtl/svm_seq_pkg.sv | 19 +
 rtl/svm_seq_watchdog.sv | 30 +++
 rtl/svm_sample_sequencer.sv | 142 ++++++++++++++
 tb/tb_svm_sample_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svm_seq_pkg.sv
// Shared state encoding, default sizes and width helper for the SVM sample sequencer.
package svm_seq_pkg;

    localparam int unsigned N_FEATURES_DEFAULT  = 17;
    localparam int unsigned INPUT_WIDTH_DEFAULT = 4;
    localparam int unsigned CLASS_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/svm_seq_watchdog.sv
// RUN-phase watchdog: counts cycles spent in RUN and flags the last allowed one.
// Only instantiated when SEQ_TIMEOUT_EN is defined.
module svm_seq_watchdog
    import svm_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic timeout
);

    localparam int unsigned    CntW   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;

    // Held at zero outside RUN so every RUN entry starts a fresh count.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            cnt_q <= '0;
        end else if (cnt_q != CntMax) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = run && (cnt_q == CntMax);

endmodule

// File: rtl/svm_sample_sequencer.sv
// Collects N_FEATURES features into a packed sample, runs the classifier and hands off the class.
// Optional RUN watchdog enabled by defining SEQ_TIMEOUT_EN.
module svm_sample_sequencer
    import svm_seq_pkg::*;
#(
    parameter int unsigned N_FEATURES     = N_FEATURES_DEFAULT,
    parameter int unsigned INPUT_WIDTH    = INPUT_WIDTH_DEFAULT,
    parameter int unsigned CLASS_WIDTH    = CLASS_WIDTH_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    input  logic [INPUT_WIDTH-1:0]            s_feat,
    output logic                              s_ready,
    output logic [N_FEATURES*INPUT_WIDTH-1:0] feat_vec,
    output logic                              clf_rst_n,
    input  logic                              clf_ready,
    input  logic [CLASS_WIDTH-1:0]            clf_class,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [CLASS_WIDTH-1:0]            res_class,
    output logic                              res_err,
    output logic [15:0]                       sample_cnt
);

    localparam int unsigned     VecW    = N_FEATURES * INPUT_WIDTH;
    localparam int unsigned     IdxW    = cnt_width(N_FEATURES);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_FEATURES - 1);

    seq_state_e              state_q, state_d;
    logic [IdxW-1:0]         feat_idx_q, feat_idx_d;
    logic [VecW-1:0]         feat_vec_q, feat_vec_d;
    logic [CLASS_WIDTH-1:0]  res_class_q, res_class_d;
    logic [15:0]             sample_cnt_q, sample_cnt_d;
    logic                    clf_ready_q;
    logic                    clf_done;
    logic                    in_run;
    logic                    timeout;

    assign in_run = (state_q == RUN);
    // Rising edge only, so a ready left high from a previous run is ignored.
    assign clf_done = clf_ready && !clf_ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LOAD;
            feat_idx_q   <= '0;
            feat_vec_q   <= '0;
            res_class_q  <= '0;
            sample_cnt_q <= '0;
            clf_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            feat_idx_q   <= feat_idx_d;
            feat_vec_q   <= feat_vec_d;
            res_class_q  <= res_class_d;
            sample_cnt_q <= sample_cnt_d;
            clf_ready_q  <= clf_ready;
        end
    end

    always_comb begin
        state_d      = state_q;
        feat_idx_d   = feat_idx_q;
        feat_vec_d   = feat_vec_q;
        res_class_d  = res_class_q;
        sample_cnt_d = sample_cnt_q;
        unique case (state_q)
            LOAD: begin
                if (s_valid) begin
                    // First feature ends up in the MSB slice once the sample is complete.
                    feat_vec_d = {feat_vec_q[VecW-INPUT_WIDTH-1:0], s_feat};
                    if (feat_idx_q == LastIdx) begin
                        feat_idx_d = '0;
                        state_d    = RUN;
                    end else begin
                        feat_idx_d = feat_idx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (clf_done) begin
                    res_class_d = clf_class;
                    state_d     = DONE;
                end else if (timeout) begin
                    res_class_d = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    sample_cnt_d = sample_cnt_q + 1'b1;
                    state_d      = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

`ifdef SEQ_TIMEOUT_EN
    logic res_err_q;

    svm_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .run    (in_run),
        .timeout(timeout)
    );

    // A completion edge coinciding with the timeout counts as a clean result.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_err_q <= 1'b0;
        end else if (in_run) begin
            if (clf_done) begin
                res_err_q <= 1'b0;
            end else if (timeout) begin
                res_err_q <= 1'b1;
            end
        end
    end

    assign res_err = res_err_q;
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign res_err            = 1'b0;
`endif

    assign s_ready    = (state_q == LOAD);
    assign clf_rst_n  = in_run;
    assign res_valid  = (state_q == DONE);
    assign feat_vec   = feat_vec_q;
    assign res_class  = res_class_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_svm_sample_sequencer.sv
// Self-checking bench for svm_sample_sequencer: classifier model plus result scoreboard.
// Build with SEQ_TIMEOUT_EN defined to exercise the watchdog variant.
module tb_svm_sample_sequencer;

    localparam int NF = 17;
    localparam int IW = 4;
    localparam int CW = 4;
    localparam int TO = 64;
    localparam int VW = NF * IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic [IW-1:0] s_feat;
    logic          s_ready;
    logic [VW-1:0] feat_vec;
    logic          clf_rst_n;
    logic          clf_ready = 1'b0;
    logic [CW-1:0] clf_class;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_class;
    logic          res_err;
    logic [15:0]   sample_cnt;

    int          pass_cnt = 0;
    int          check_cnt = 0;
    logic [4:0]  sb_q[$];   // {class, err}
    logic [15:0] exp_cnt;
    bit          clf_en = 1'b1;
    bit          clf_stale = 1'b0;
    int          clf_lat = 18;
    int          run_cyc = 0;

    svm_sample_sequencer #(
        .N_FEATURES    (NF),
        .INPUT_WIDTH   (IW),
        .CLASS_WIDTH   (CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_feat    (s_feat),
        .s_ready   (s_ready),
        .feat_vec  (feat_vec),
        .clf_rst_n (clf_rst_n),
        .clf_ready (clf_ready),
        .clf_class (clf_class),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_class (res_class),
        .res_err   (res_err),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    // Classifier model: ready rises clf_lat cycles into RUN; in stale mode it idles high.
    always @(posedge clk) begin
        if (!clf_rst_n) begin
            run_cyc   <= 0;
            clf_ready <= clf_stale;
        end else begin
            run_cyc   <= run_cyc + 1;
            clf_ready <= clf_en && (run_cyc + 1 >= clf_lat);
        end
    end

    task automatic apply_reset(input int cycles);
        rst       = 1'b1;
        s_valid   = 1'b0;
        res_ready = 1'b0;
        repeat (cycles) @(negedge clk);
        rst     = 1'b0;
        exp_cnt = '0;
        sb_q.delete();
    endtask

    // Starts and ends at a negedge; vec is the model of feat_vec after the shifts.
    task automatic send_sample(input int base, input int nfeat, output logic [VW-1:0] vec);
        logic [IW-1:0] f;
        vec = '0;
        for (int i = 0; i < nfeat; i++) begin
            f = IW'((base + i) & 15);
            check_cnt++;
            if (s_ready !== 1'b1 || clf_rst_n !== 1'b0)
                $display("FAIL load_handshake feat %0d: s_ready=%b clf_rst_n=%b, need 1/0",
                         i, s_ready, clf_rst_n);
            else pass_cnt++;
            s_valid = 1'b1;
            s_feat  = f;
            @(posedge clk);
            vec = {vec[VW-IW-1:0], f};
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    // Entered at the negedge right after the last feature handshake.
    task automatic collect(input int exp_n, input int hold, input logic [VW-1:0] vec);
        int         n;
        bit         moved;
        logic [4:0] exp;
        n     = 0;
        moved = 1'b0;
        exp   = '0;
        while (res_valid !== 1'b1 && n < 400) begin
            if (feat_vec !== vec) moved = 1'b1;
            @(negedge clk);
            n++;
        end
        check_cnt++;
        if (n !== exp_n) $display("FAIL result_latency: got %0d cycles, need %0d", n, exp_n);
        else pass_cnt++;
        check_cnt++;
        if (moved !== 1'b0) $display("FAIL run_feat_vec_stable: feat_vec changed during RUN");
        else pass_cnt++;
        check_cnt++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard: result with no expected entry");
        end else begin
            pass_cnt++;
            exp = sb_q.pop_front();
            check_cnt++;
            if (res_class !== exp[4:1])
                $display("FAIL res_class: got %h, need %h", res_class, exp[4:1]);
            else pass_cnt++;
            check_cnt++;
            if (res_err !== exp[0]) $display("FAIL res_err: got %b, need %b", res_err, exp[0]);
            else pass_cnt++;
        end
        for (int c = 0; c < hold; c++) begin
            s_valid = 1'b1;
            s_feat  = 4'hA;
            @(negedge clk);
            check_cnt++;
            if (res_valid !== 1'b1 || res_class !== exp[4:1] || s_ready !== 1'b0 ||
                feat_vec !== vec)
                $display("FAIL done_hold cycle %0d: valid=%b class=%h s_ready=%b vec=%h, need 1/%h/0/%h",
                         c, res_valid, res_class, s_ready, feat_vec, exp[4:1], vec);
            else pass_cnt++;
        end
        s_valid   = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_cnt++;
        check_cnt++;
        if (res_valid !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL handoff_state: res_valid=%b s_ready=%b, need 0/1", res_valid, s_ready);
        else pass_cnt++;
        check_cnt++;
        if (sample_cnt !== exp_cnt)
            $display("FAIL sample_cnt: got %h, need %h", sample_cnt, exp_cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        apply_reset(3);
        check_cnt++;
        if (s_ready !== 1'b1 || clf_rst_n !== 1'b0 || res_valid !== 1'b0)
            $display("FAIL reset_ctrl: s_ready=%b clf_rst_n=%b res_valid=%b, need 1/0/0",
                     s_ready, clf_rst_n, res_valid);
        else pass_cnt++;
        check_cnt++;
        if (res_class !== '0 || res_err !== 1'b0)
            $display("FAIL reset_result: class=%h err=%b, need 0/0", res_class, res_err);
        else pass_cnt++;
        check_cnt++;
        if (sample_cnt !== 16'h0000) $display("FAIL reset_cnt: got %h, need 0000", sample_cnt);
        else pass_cnt++;
        check_cnt++;
        if (feat_vec !== '0) $display("FAIL reset_vec: got %h, need 0", feat_vec);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [VW-1:0] vec;
        clf_en    = 1'b1;
        clf_lat   = 18;
        clf_class = 4'd7;
        send_sample(1, NF, vec);
        check_cnt++;
        if (feat_vec !== 68'h123456789ABCDEF01)
            $display("FAIL stream_vec: got %h, need 123456789abcdef01", feat_vec);
        else pass_cnt++;
        check_cnt++;
        if (clf_rst_n !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL run_entry: clf_rst_n=%b s_ready=%b, need 1/0", clf_rst_n, s_ready);
        else pass_cnt++;
        sb_q.push_back({4'd7, 1'b0});
        collect(19, 5, vec);
    endtask

    task automatic test_reset_mid_load();
        logic [VW-1:0] vec;
        send_sample(1, 9, vec);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = '0;
        check_cnt++;
        if (feat_vec !== '0 || sample_cnt !== 16'h0000 || res_class !== '0)
            $display("FAIL mid_load_reset: vec=%h cnt=%h class=%h, need 0/0/0",
                     feat_vec, sample_cnt, res_class);
        else pass_cnt++;
        check_cnt++;
        if (s_ready !== 1'b1 || clf_rst_n !== 1'b0 || res_valid !== 1'b0)
            $display("FAIL mid_load_ctrl: s_ready=%b clf_rst_n=%b res_valid=%b, need 1/0/0",
                     s_ready, clf_rst_n, res_valid);
        else pass_cnt++;
        clf_lat   = 4;
        clf_class = 4'd3;
        send_sample(6, NF, vec);
        check_cnt++;
        if (feat_vec !== vec) $display("FAIL fresh_vec: got %h, need %h", feat_vec, vec);
        else pass_cnt++;
        sb_q.push_back({4'd3, 1'b0});
        collect(5, 0, vec);
    endtask

    task automatic test_stale_ready();
        logic [VW-1:0] vec;
        clf_stale = 1'b1;
        clf_lat   = 6;
        clf_class = 4'd9;
        send_sample(11, NF, vec);
        sb_q.push_back({4'd9, 1'b0});
        collect(7, 0, vec);
        clf_stale = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] vec;
        logic [CW-1:0] cls;
        clf_lat = 1;
        for (int k = 0; k < 12; k++) begin
            cls       = CW'($urandom_range(0, 15));
            clf_class = cls;
            send_sample(k * 3, NF, vec);
            sb_q.push_back({cls, 1'b0});
            collect(2, 0, vec);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [VW-1:0] vec;
        clf_en = 1'b0;
        send_sample(4, NF, vec);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        exp_cnt = '0;
        check_cnt++;
        if (clf_rst_n !== 1'b0 || s_ready !== 1'b1 || res_valid !== 1'b0 || feat_vec !== '0 ||
            sample_cnt !== 16'h0000)
            $display("FAIL mid_run_reset: clf_rst_n=%b s_ready=%b valid=%b vec=%h cnt=%h, need 0/1/0/0/0",
                     clf_rst_n, s_ready, res_valid, feat_vec, sample_cnt);
        else pass_cnt++;
        clf_en = 1'b1;
    endtask

    task automatic test_timeout();
        logic [VW-1:0] vec;
`ifdef SEQ_TIMEOUT_EN
        clf_en = 1'b0;
        send_sample(2, NF, vec);
        sb_q.push_back({4'd0, 1'b1});
        collect(TO, 0, vec);
        // Completion edge lands in the last watchdog cycle and must win.
        clf_en    = 1'b1;
        clf_lat   = TO - 1;
        clf_class = 4'd12;
        send_sample(8, NF, vec);
        sb_q.push_back({4'd12, 1'b0});
        collect(TO, 0, vec);
`else
        clf_en = 1'b0;
        send_sample(2, NF, vec);
        repeat (100) @(negedge clk);
        check_cnt++;
        if (clf_rst_n !== 1'b1 || res_valid !== 1'b0 || s_ready !== 1'b0 || res_err !== 1'b0)
            $display("FAIL run_wait: clf_rst_n=%b valid=%b s_ready=%b err=%b, need 1/0/0/0",
                     clf_rst_n, res_valid, s_ready, res_err);
        else pass_cnt++;
        apply_reset(2);
        clf_en = 1'b1;
`endif
    endtask

    task automatic test_wrap();
        logic [VW-1:0] vec;
        // Preload the counter instead of running 65535 real results.
        force dut.sample_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.sample_cnt_q;
        exp_cnt = 16'hFFFF;
        check_cnt++;
        if (sample_cnt !== 16'hFFFF) $display("FAIL wrap_preload: got %h, need ffff", sample_cnt);
        else pass_cnt++;
        clf_lat   = 1;
        clf_class = 4'd5;
        send_sample(9, NF, vec);
        sb_q.push_back({4'd5, 1'b0});
        collect(2, 0, vec);
        check_cnt++;
        if (sample_cnt !== 16'h0000) $display("FAIL wrap_zero: got %h, need 0000", sample_cnt);
        else pass_cnt++;
    endtask

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_feat    = '0;
        res_ready = 1'b0;
        clf_class = '0;
        exp_cnt   = '0;
        test_reset();
        test_stream();
        test_reset_mid_load();
        test_stale_ready();
        test_back_to_back();
        test_reset_mid_run();
        test_timeout();
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not finish, checks passed %0d of %0d",
                 pass_cnt, check_cnt);
        $fatal(1);
    end

endmodule
